data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/gpu_mem_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/data_mem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared memory-side definitions for the responder and its arbiter.
// Pure types/constants; no logic, no latency, no backpressure.
package gpu_mem_pkg;

    localparam int ADDR_BITS = 8;
    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2,
        RELEASE = 2'd3
    } rsp_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping; one-hot grant plus index.
// Combinational (0 cycles); holds no state, so it applies no backpressure of its own.
module rr_arbiter #(
    parameter int THREADS = 4,
    parameter int IDX_W   = (THREADS > 1) ? $clog2(THREADS) : 1
) (
    input  logic [THREADS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [THREADS-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               vld
);

    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        for (int i = 0; i < THREADS; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= THREADS) begin
                j = j - THREADS;
            end
            if (!vld && req[j]) begin
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
                vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Serves THREADS LSU ports from a 256x8 byte array, one request at a time, round-robin; DMEM_STATS_EN adds read/write counters.
// Ready pulses LATENCY+1 cycles after a valid is sampled in IDLE; ungranted requests wait by holding their valid.
module data_mem_responder
    import gpu_mem_pkg::*;
#(
    parameter int THREADS = 4,
    parameter int LATENCY = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [THREADS-1:0]             mem_read_valid,
    input  logic [THREADS*ADDR_BITS-1:0]   mem_read_address,
    input  logic [THREADS-1:0]             mem_write_valid,
    input  logic [THREADS*ADDR_BITS-1:0]   mem_write_address,
    input  logic [THREADS*DATA_BITS-1:0]   mem_write_data,
    output logic [THREADS-1:0]             mem_read_ready,
    output logic [THREADS*DATA_BITS-1:0]   mem_read_data,
    output logic [THREADS-1:0]             mem_write_ready,
    output logic                           busy
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]                    read_count,
    output logic [15:0]                    write_count
`endif
);

    localparam int IDX_W = (THREADS > 1) ? $clog2(THREADS) : 1;

    rsp_state_e                   state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [IDX_W-1:0]             ptr_q, ptr_d;
    logic                         op_wr_q, op_wr_d;
    logic [ADDR_BITS-1:0]         addr_q, addr_d;
    logic [DATA_BITS-1:0]         wdata_q, wdata_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic [THREADS*DATA_BITS-1:0] rdata_q, rdata_d;

    logic [DATA_BITS-1:0]         mem_array [2**ADDR_BITS];

    logic [THREADS-1:0]           arb_req, arb_gnt;
    logic [IDX_W-1:0]             arb_idx;
    logic                         arb_vld;

    logic                         sel_wr;
    logic [ADDR_BITS-1:0]         sel_rd_addr, sel_wr_addr;
    logic [DATA_BITS-1:0]         sel_wdata;
    logic                         held_vld;

    assign arb_req = mem_read_valid | mem_write_valid;

    rr_arbiter #(
        .THREADS (THREADS),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req (arb_req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .vld (arb_vld)
    );

    // Write wins over a simultaneous read from the same thread; the read re-arbitrates later.
    assign sel_wr = |(arb_gnt & mem_write_valid);

    always_comb begin
        sel_rd_addr = '0;
        sel_wr_addr = '0;
        sel_wdata   = '0;
        held_vld    = 1'b0;
        for (int t = 0; t < THREADS; t++) begin
            if (arb_gnt[t]) begin
                sel_rd_addr = mem_read_address[t*ADDR_BITS +: ADDR_BITS];
                sel_wr_addr = mem_write_address[t*ADDR_BITS +: ADDR_BITS];
                sel_wdata   = mem_write_data[t*DATA_BITS +: DATA_BITS];
            end
            if (IDX_W'(t) == idx_q) begin
                held_vld = op_wr_q ? mem_write_valid[t] : mem_read_valid[t];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    idx_d   = arb_idx;
                    ptr_d   = (arb_idx == IDX_W'(THREADS - 1)) ? '0 : arb_idx + 1'b1;
                    op_wr_d = sel_wr;
                    addr_d  = sel_wr ? sel_wr_addr : sel_rd_addr;
                    wdata_d = sel_wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESPOND;
                    // Capture read data on entry so it is on the bus alongside the ready pulse.
                    if (!op_wr_q) begin
                        for (int t = 0; t < THREADS; t++) begin
                            if (IDX_W'(t) == idx_q) begin
                                rdata_d[t*DATA_BITS +: DATA_BITS] = mem_array[addr_q];
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESPOND: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!held_vld) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Array commits only from RESPOND, so a reset that lands earlier leaves it untouched.
    always_ff @(posedge clock) begin
        if (state_q == RESPOND && op_wr_q) begin
            mem_array[addr_q] <= wdata_q;
        end
    end

    always_comb begin
        mem_read_ready  = '0;
        mem_write_ready = '0;
        for (int t = 0; t < THREADS; t++) begin
            if (state_q == RESPOND && IDX_W'(t) == idx_q) begin
                mem_write_ready[t] = op_wr_q;
                mem_read_ready[t]  = !op_wr_q;
            end
        end
    end

    assign mem_read_data = rdata_q;
    assign busy          = (state_q != IDLE);

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (state_q == RESPOND) begin
            if (op_wr_q) begin
                wr_cnt_d = wr_cnt_q + 16'd1;
            end else begin
                rd_cnt_d = rd_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign read_count  = rd_cnt_q;
    assign write_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (THREADS=4, LATENCY=2); build with DMEM_STATS_EN to cover the counters.
module tb_data_mem_responder;

    localparam int T = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [T-1:0]   mem_read_valid, mem_write_valid;
    logic [T-1:0]   mem_read_ready, mem_write_ready;
    logic [T*8-1:0] mem_read_address, mem_write_address, mem_write_data, mem_read_data;
    logic           busy;
`ifdef DMEM_STATS_EN
    logic [15:0]    read_count, write_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    data_mem_responder #(.THREADS(T), .LATENCY(2)) dut (
        .clock             (clock),
        .reset             (reset),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_write_valid   (mem_write_valid),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .mem_write_ready   (mem_write_ready),
        .busy              (busy)
`ifdef DMEM_STATS_EN
        ,
        .read_count        (read_count),
        .write_count       (write_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One request on one thread; checks latency, single-cycle pulse and release back to idle.
    task automatic do_op(input string tag, input bit wr, input int t, input logic [7:0] a,
                         input logic [7:0] d, output logic [7:0] rd);
        int lat;
        @(negedge clock);
        if (wr) begin
            mem_write_valid[t]          = 1'b1;
            mem_write_address[8*t +: 8] = a;
            mem_write_data[8*t +: 8]    = d;
        end else begin
            mem_read_valid[t]           = 1'b1;
            mem_read_address[8*t +: 8]  = a;
        end
        lat = -1;
        rd  = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (wr ? mem_write_ready[t] : mem_read_ready[t]) begin
                lat = k;
                rd  = mem_read_data[8*t +: 8];
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'd3);
        mem_write_valid[t] = 1'b0;
        mem_read_valid[t]  = 1'b0;
        @(negedge clock);
        check({tag, "_pulse"}, 32'(wr ? mem_write_ready[t] : mem_read_ready[t]), 32'd0);
        check({tag, "_busy_rel"}, 32'(busy), 32'd1);
        @(negedge clock);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    // All four threads read 0x50+t together; expects service order 0,1,2,3 with data 0xC0+t.
    task automatic burst(input string tag);
        int seen;
        @(negedge clock);
        for (int t = 0; t < T; t++) begin
            mem_read_valid[t]          = 1'b1;
            mem_read_address[8*t +: 8] = 8'(8'h50 + t);
        end
        seen = 0;
        for (int k = 0; k < 80 && seen < 4; k++) begin
            @(negedge clock);
            if (mem_read_ready != '0) begin
                check({tag, "_onehot"}, 32'($countones(mem_read_ready)), 32'd1);
                for (int t = 0; t < T; t++) begin
                    if (mem_read_ready[t]) begin
                        check({tag, "_order"}, 32'(t), 32'(seen));
                        check({tag, "_data"}, 32'(mem_read_data[8*t +: 8]), 32'(8'hC0 + t));
                        mem_read_valid[t] = 1'b0;
                        seen++;
                    end
                end
            end
        end
        check({tag, "_count"}, 32'(seen), 32'd4);
        mem_read_valid = '0;
        @(negedge clock);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int pulses;
        bit wseen, rseen;

        reset             = 1'b0;
        mem_read_valid    = '0;
        mem_write_valid   = '0;
        mem_read_address  = '0;
        mem_write_address = '0;
        mem_write_data    = '0;
        repeat (2) @(negedge clock);
        check("rst_rd_rdy", 32'(mem_read_ready), 32'd0);
        check("rst_wr_rdy", 32'(mem_write_ready), 32'd0);
        check("rst_rdata", mem_read_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef DMEM_STATS_EN
        check("rst_rd_cnt", 32'(read_count), 32'd0);
        check("rst_wr_cnt", 32'(write_count), 32'd0);
`endif
        reset = 1'b1;

        // Write then read back on thread 0.
        do_op("t0_wr", 1'b1, 0, 8'h10, 8'hA5, rd);
        do_op("t0_rd", 1'b0, 0, 8'h10, 8'h00, rd);
        check("t0_rd_data", 32'(rd), 32'hA5);

        // Preload 0x50..0x53 with 0xC0..0xC3, then two simultaneous bursts.
        for (int t = 0; t < T; t++) begin
            do_op("pre_wr", 1'b1, t, 8'(8'h50 + t), 8'(8'hC0 + t), rd);
        end
        burst("burst1");
        check("held_t0_data", 32'(mem_read_data[7:0]), 32'hC0);
        burst("burst2");

        // Thread 2: write and read the same address in the same cycle.
        @(negedge clock);
        mem_write_valid[2]        = 1'b1;
        mem_write_address[23:16]  = 8'h20;
        mem_write_data[23:16]     = 8'h3C;
        mem_read_valid[2]         = 1'b1;
        mem_read_address[23:16]   = 8'h20;
        wseen = 1'b0;
        rseen = 1'b0;
        for (int k = 0; k < 60 && !rseen; k++) begin
            @(negedge clock);
            if (mem_write_ready[2]) begin
                wseen              = 1'b1;
                mem_write_valid[2] = 1'b0;
            end
            if (mem_read_ready[2]) begin
                rseen = 1'b1;
                check("rw_write_first", 32'(wseen), 32'd1);
                check("rw_data", 32'(mem_read_data[23:16]), 32'h3C);
                mem_read_valid[2] = 1'b0;
            end
        end
        check("rw_read_done", 32'(rseen), 32'd1);
        mem_write_valid = '0;
        mem_read_valid  = '0;
        repeat (2) @(negedge clock);

        // Thread 1 holds its read valid 5 cycles past ready.
        @(negedge clock);
        mem_read_valid[1]        = 1'b1;
        mem_read_address[15:8]   = 8'h51;
        pulses = 0;
        for (int k = 0; k < 20 && pulses == 0; k++) begin
            @(negedge clock);
            if (mem_read_ready[1]) pulses++;
        end
        check("hold_data", 32'(mem_read_data[15:8]), 32'hC1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (mem_read_ready[1]) pulses++;
            check("hold_busy", 32'(busy), 32'd1);
        end
        check("hold_pulses", 32'(pulses), 32'd1);
        mem_read_valid[1] = 1'b0;
        repeat (2) @(negedge clock);
        check("hold_busy_done", 32'(busy), 32'd0);

        // Reset lands in ACCESS of a write; array must keep the earlier value.
        do_op("pre40", 1'b1, 0, 8'h40, 8'h11, rd);
        @(negedge clock);
        mem_write_valid[0]      = 1'b1;
        mem_write_address[7:0]  = 8'h40;
        mem_write_data[7:0]     = 8'h77;
        @(negedge clock);
        check("abort_busy_pre", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wr_rdy", 32'(mem_write_ready), 32'd0);
        check("abort_rd_rdy", 32'(mem_read_ready), 32'd0);
        check("abort_rdata", mem_read_data, 32'd0);
        mem_write_valid = '0;
        @(negedge clock);
        reset = 1'b1;
        do_op("post40", 1'b0, 0, 8'h40, 8'h00, rd);
        check("abort_keep", 32'(rd), 32'h11);

        // Since the abort reset: 1 read so far; 3 writes and 1 more read follow.
        do_op("st_w0", 1'b1, 1, 8'h60, 8'h01, rd);
        do_op("st_w1", 1'b1, 2, 8'h61, 8'h02, rd);
        do_op("st_w2", 1'b1, 3, 8'h62, 8'h03, rd);
        do_op("st_r1", 1'b0, 3, 8'h61, 8'h00, rd);
        check("st_r1_data", 32'(rd), 32'h02);
`ifdef DMEM_STATS_EN
        check("stat_wr_cnt", 32'(write_count), 32'd3);
        check("stat_rd_cnt", 32'(read_count), 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
